// File: rtl/bist_resp_cmp_if.sv
// Signal bundle between the BIST controller / memory read port and the response analyzer.
// The controller side drives reads and returned data; the analyzer side reports results.
interface bist_resp_cmp_if #(
    parameter int pDATA_WIDTH = 2,
    parameter int pADDR_WIDTH = 4,
    parameter int pCNT_WIDTH  = 8
);
    logic                   cmp_clr;
    logic                   rd_en;
    logic [pADDR_WIDTH-1:0] rd_addr;
    logic                   pat_sel;
    logic                   test_end;
    logic [pDATA_WIDTH-1:0] mem_dout;

    logic                   cmp_fail;
    logic [pCNT_WIDTH-1:0]  fail_cnt;
    logic                   first_fail_vld;
    logic [pADDR_WIDTH-1:0] first_fail_addr;
    logic [pDATA_WIDTH-1:0] fail_bits;
    logic                   cmp_done;

    modport master (
        output cmp_clr, rd_en, rd_addr, pat_sel, test_end, mem_dout,
        input  cmp_fail, fail_cnt, first_fail_vld, first_fail_addr, fail_bits, cmp_done
    );

    modport slave (
        input  cmp_clr, rd_en, rd_addr, pat_sel, test_end, mem_dout,
        output cmp_fail, fail_cnt, first_fail_vld, first_fail_addr, fail_bits, cmp_done
    );
endinterface

// File: rtl/bist_resp_cmp.sv
// MBIST response analyzer: tags each read with its expected pattern, compares the returned
// data after the memory read latency, and accumulates pass/fail results until drained.
//   state | meaning
//   IDLE  | no read seen since reset/clear
//   RUN   | reads being issued, test_end not yet seen
//   DRAIN | test_end seen, waiting for in-flight reads to be compared
//   DONE  | all reads compared; new reads and test_end ignored
module bist_resp_cmp #(
    parameter int pDATA_WIDTH = 2,
    parameter int pADDR_WIDTH = 4,
    parameter int pRD_LAT     = 1,
    parameter int pCNT_WIDTH  = 8
) (
    input  logic           bist_clk,
    input  logic           bist_rst_n,
    bist_resp_cmp_if.slave bus
);
    localparam int LAST = pRD_LAT - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [pRD_LAT-1:0]     vld_q, vld_d, vld_shift;
    logic [pRD_LAT-1:0]     exp_q, exp_d;
    logic [pADDR_WIDTH-1:0] addr_q [pRD_LAT];
    logic [pADDR_WIDTH-1:0] addr_d [pRD_LAT];

    logic                   cmp_fail_q, cmp_fail_d;
    logic [pCNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic                   ffv_q, ffv_d;
    logic [pADDR_WIDTH-1:0] ffa_q, ffa_d;
    logic [pDATA_WIDTH-1:0] fail_bits_q, fail_bits_d;

    logic                   rd_acc;
    logic                   rd_fail;
    logic [pDATA_WIDTH-1:0] mm;

    assign rd_acc  = bus.rd_en && (state_q != ST_DONE);
    assign mm      = bus.mem_dout ^ {pDATA_WIDTH{exp_q[LAST]}};
    assign rd_fail = vld_q[LAST] && (mm != '0);

    always_comb begin : pipe_next
        vld_shift = '0;
        exp_d     = '0;
        for (int i = 0; i < pRD_LAT; i++) begin
            addr_d[i] = '0;
        end
        vld_shift[0] = rd_acc;
        exp_d[0]     = bus.pat_sel;
        addr_d[0]    = bus.rd_addr;
        for (int i = 1; i < pRD_LAT; i++) begin
            vld_shift[i] = vld_q[i-1];
            exp_d[i]     = exp_q[i-1];
            addr_d[i]    = addr_q[i-1];
        end
        vld_d = bus.cmp_clr ? '0 : vld_shift;
    end

    always_comb begin : result_next
        cmp_fail_d  = cmp_fail_q;
        fail_cnt_d  = fail_cnt_q;
        ffv_d       = ffv_q;
        ffa_d       = ffa_q;
        fail_bits_d = fail_bits_q;
        if (rd_fail) begin
            cmp_fail_d  = 1'b1;
            fail_bits_d = fail_bits_q | mm;
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + pCNT_WIDTH'(1);
            end
            if (!ffv_q) begin
                ffv_d = 1'b1;
                ffa_d = addr_q[LAST];
            end
        end
        if (bus.cmp_clr) begin
            cmp_fail_d  = 1'b0;
            fail_cnt_d  = '0;
            ffv_d       = 1'b0;
            ffa_d       = '0;
            fail_bits_d = '0;
        end
    end

    // vld_shift is the pipeline occupancy after this edge; empty means the last
    // in-flight compare registers on the same edge that enters DONE.
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.test_end)   state_d = ST_DRAIN;
                else if (bus.rd_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.test_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vld_shift == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.cmp_clr) state_d = ST_IDLE;
    end

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            exp_q       <= '0;
            for (int i = 0; i < pRD_LAT; i++) begin
                addr_q[i] <= '0;
            end
            cmp_fail_q  <= 1'b0;
            fail_cnt_q  <= '0;
            ffv_q       <= 1'b0;
            ffa_q       <= '0;
            fail_bits_q <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            for (int i = 0; i < pRD_LAT; i++) begin
                addr_q[i] <= addr_d[i];
            end
            cmp_fail_q  <= cmp_fail_d;
            fail_cnt_q  <= fail_cnt_d;
            ffv_q       <= ffv_d;
            ffa_q       <= ffa_d;
            fail_bits_q <= fail_bits_d;
        end
    end

    assign bus.cmp_fail        = cmp_fail_q;
    assign bus.fail_cnt        = fail_cnt_q;
    assign bus.first_fail_vld  = ffv_q;
    assign bus.first_fail_addr = ffa_q;
    assign bus.fail_bits       = fail_bits_q;
    assign bus.cmp_done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_bist_resp_cmp.sv
// Scoreboard bench for bist_resp_cmp: two instances (read latency 1 / 8-bit counter and
// read latency 3 / 4-bit counter) share stimulus; a memory delay line feeds each one.
`timescale 1ns/1ps
module tb_bist_resp_cmp;
    typedef struct packed {
        logic [7:0] cnt;
        logic       fail;
        logic       ffv;
        logic [3:0] ffa;
        logic [1:0] bits;
    } res_t;

    typedef struct {
        int   due;
        res_t r;
    } sb_t;

    logic bist_clk   = 1'b0;
    logic bist_rst_n = 1'b0;
    always #5 bist_clk = ~bist_clk;

    logic       d_clr = 1'b0, d_rd = 1'b0, d_pat = 1'b0, d_te = 1'b0;
    logic [3:0] d_addr = '0;
    logic [1:0] d_dv = '0;
    logic [1:0] dout_a, dout_b;
    logic [1:0] hist [2][4];

    bist_resp_cmp_if #(.pDATA_WIDTH(2), .pADDR_WIDTH(4), .pCNT_WIDTH(8)) bus_a ();
    bist_resp_cmp_if #(.pDATA_WIDTH(2), .pADDR_WIDTH(4), .pCNT_WIDTH(4)) bus_b ();

    assign bus_a.cmp_clr = d_clr;  assign bus_b.cmp_clr = d_clr;
    assign bus_a.rd_en = d_rd;     assign bus_b.rd_en = d_rd;
    assign bus_a.rd_addr = d_addr; assign bus_b.rd_addr = d_addr;
    assign bus_a.pat_sel = d_pat;  assign bus_b.pat_sel = d_pat;
    assign bus_a.test_end = d_te;  assign bus_b.test_end = d_te;
    assign bus_a.mem_dout = dout_a;
    assign bus_b.mem_dout = dout_b;

    bist_resp_cmp #(.pDATA_WIDTH(2), .pADDR_WIDTH(4), .pRD_LAT(1), .pCNT_WIDTH(8)) u_dut_a (
        .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bus(bus_a.slave));
    bist_resp_cmp #(.pDATA_WIDTH(2), .pADDR_WIDTH(4), .pRD_LAT(3), .pCNT_WIDTH(4)) u_dut_b (
        .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bus(bus_b.slave));

    res_t act [2];
    logic act_done [2];
    assign act[0] = {bus_a.fail_cnt, bus_a.cmp_fail, bus_a.first_fail_vld,
                     bus_a.first_fail_addr, bus_a.fail_bits};
    assign act[1] = {4'h0, bus_b.fail_cnt, bus_b.cmp_fail, bus_b.first_fail_vld,
                     bus_b.first_fail_addr, bus_b.fail_bits};
    assign act_done[0] = bus_a.cmp_done;
    assign act_done[1] = bus_b.cmp_done;

    // reference model state: results accumulated in read order, plus test phase
    res_t m_res [2];
    res_t cur [2];
    bit   m_done [2];
    bit   m_drain [2];
    int   m_last [2];
    sb_t  sbq_a [$];
    sb_t  sbq_b [$];
    int   edge_no = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int d);
        return (d == 0) ? 255 : 15;
    endfunction

    task automatic push_exp(input int d, input sb_t e);
        if (d == 0) sbq_a.push_back(e);
        else        sbq_b.push_back(e);
    endtask

    task automatic model_clear(input int d);
        m_res[d]   = '0;
        m_done[d]  = 1'b0;
        m_drain[d] = 1'b0;
        m_last[d]  = -100;
        if (d == 0) sbq_a.delete();
        else        sbq_b.delete();
    endtask

    task automatic model_edge(input int d);
        logic [1:0] mm;
        sb_t        e;
        if (d_clr) begin
            model_clear(d);
            e.due = edge_no;
            e.r   = '0;
            push_exp(d, e);
            return;
        end
        if (d_rd && !m_done[d]) begin
            mm = d_dv ^ {2{d_pat}};
            if (mm != 2'b00) begin
                m_res[d].fail = 1'b1;
                m_res[d].bits = m_res[d].bits | mm;
                if (int'(m_res[d].cnt) < cmax_of(d)) m_res[d].cnt = m_res[d].cnt + 8'd1;
                if (!m_res[d].ffv) begin
                    m_res[d].ffv = 1'b1;
                    m_res[d].ffa = d_addr;
                end
            end
            m_last[d] = edge_no;
            e.due = edge_no + lat_of(d);
            e.r   = m_res[d];
            push_exp(d, e);
        end
        if (m_drain[d] && !m_done[d] && (edge_no - m_last[d] >= lat_of(d))) m_done[d] = 1'b1;
        else if (d_te && !m_drain[d]) m_drain[d] = 1'b1;
    endtask

    task automatic check(input int d, input string nm, input res_t er, input bit ed);
        n_chk++;
        if (act[d] === er && act_done[d] === ed) n_pass++;
        else $display("FAIL %s dut%0d edge %0d: got cnt=%0d fail=%0b ffv=%0b ffa=%0d bits=%b done=%0b, want cnt=%0d fail=%0b ffv=%0b ffa=%0d bits=%b done=%0b",
                      nm, d, edge_no, act[d].cnt, act[d].fail, act[d].ffv, act[d].ffa, act[d].bits,
                      act_done[d], er.cnt, er.fail, er.ffv, er.ffa, er.bits, ed);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            cur[d] = '0;
        end
    end

    // model + memory: update reference at each edge, then present delayed read data
    initial begin
        forever begin
            @(posedge bist_clk);
            if (bist_rst_n) begin
                edge_no++;
                for (int d = 0; d < 2; d++) model_edge(d);
            end
            #2;
            for (int d = 0; d < 2; d++) begin
                for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
                hist[d][0] = d_rd ? d_dv : 2'($urandom);
            end
            dout_a = hist[0][0];
            dout_b = hist[1][2];
        end
    end

    // monitor: pop any expectation due at this edge and compare outputs every cycle
    initial begin
        sb_t e;
        forever begin
            @(posedge bist_clk);
            #1;
            while (sbq_a.size() > 0 && sbq_a[0].due <= edge_no) begin
                e = sbq_a.pop_front();
                cur[0] = e.r;
            end
            while (sbq_b.size() > 0 && sbq_b[0].due <= edge_no) begin
                e = sbq_b.pop_front();
                cur[1] = e.r;
            end
            for (int d = 0; d < 2; d++) check(d, "scoreboard", cur[d], m_done[d]);
        end
    end

    task automatic drive(input bit rd, input logic [3:0] a, input bit p,
                         input logic [1:0] dv, input bit te, input bit clr);
        @(negedge bist_clk);
        d_rd = rd; d_addr = a; d_pat = p; d_dv = dv; d_te = te; d_clr = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic clear();
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic async_reset();
        @(negedge bist_clk);
        d_rd = 1'b0; d_te = 1'b0; d_clr = 1'b0;
        #2;
        bist_rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check(d, "async_reset", '0, 1'b0);
            model_clear(d);
            cur[d] = '0;
        end
        @(negedge bist_clk);
        bist_rst_n = 1'b1;
    endtask

    initial begin
        bit         p, te, te_sent;
        int         n;
        logic [1:0] dv;
        repeat (3) @(negedge bist_clk);
        bist_rst_n = 1'b1;
        idle(2);

        // clean run, test_end one cycle after the last read
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 1'b1, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(6);
        clear();

        // single fault at address 5, test_end with the last read
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'(i), 1'b0, (i == 5) ? 2'b01 : 2'b00, i == 15, 1'b0);
        idle(6);
        clear();

        // two faults: first address must stay 3
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'(i), 1'b0, (i == 3) ? 2'b10 : (i == 9) ? 2'b01 : 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(6);
        clear();

        // back-to-back reads, test_end with the last, then reads while done
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 8), 1'b1, (i == 2) ? 2'b01 : 2'b11, i == 3, 1'b0);
        idle(5);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(4);
        clear();

        // counter saturation
        for (int i = 0; i < 20; i++) drive(1'b1, 4'(i), 1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(5);
        clear();

        // clear with reads in flight and a fail already recorded
        drive(1'b1, 4'h1, 1'b0, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 2'b10, 1'b0, 1'b0);
        idle(4);
        drive(1'b1, 4'h7, 1'b0, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 4'h8, 1'b0, 2'b11, 1'b0, 1'b0);
        clear();
        idle(5);

        // asynchronous reset mid-cycle with reads in flight
        drive(1'b1, 4'h4, 1'b1, 2'b01, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 4'h5, 1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 4'h6, 1'b1, 2'b10, 1'b0, 1'b0);
        async_reset();
        idle(5);

        // randomized test sessions
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, 25);
            te_sent = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                p  = 1'($urandom_range(0, 1));
                dv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : {2{p}};
                te = (i == n - 1) && ($urandom_range(0, 1) == 1);
                te_sent = te_sent | te;
                drive(1'b1, 4'($urandom), p, dv, te, 1'b0);
            end
            if (!te_sent) drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
            repeat ($urandom_range(0, 8)) begin
                p = 1'($urandom_range(0, 1));
                drive($urandom_range(0, 3) == 0, 4'($urandom), p, 2'($urandom), 1'b0, 1'b0);
            end
            idle($urandom_range(0, 4));
            clear();
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
